// File: rtl/ntt_mult_stream_host.sv
// rtl/ntt_mult_stream_host.sv - stream-to-multiplier host sequencer: loads A/B, starts, drains results
module ntt_mult_stream_host #(
    parameter int N          = 256,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WIDTH-1:0]      s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH-1:0]      m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  mult_start,
    input  logic                  mult_done,
    input  logic                  mult_busy,
    output logic                  mult_load_coeff,
    output logic                  mult_load_sel,
    output logic [ADDR_WIDTH-1:0] mult_load_addr,
    output logic [WIDTH-1:0]      mult_load_data,
    output logic [ADDR_WIDTH-1:0] mult_read_addr,
    input  logic [WIDTH-1:0]      mult_read_data
);
    localparam int WCW = $clog2(2*N+1);
    localparam int RCW = ADDR_WIDTH + 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(2*N-1);
    localparam logic [RCW-1:0] N_RD      = RCW'(N);
    localparam logic [RCW-1:0] LAST_OUT  = RCW'(N-1);

    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_FLUSH = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]            r_state;
    logic                  r_live;
    logic [WCW-1:0]        r_word;
    logic                  r_frame_err;
    logic                  r_load_coeff;
    logic                  r_load_sel;
    logic [ADDR_WIDTH-1:0] r_load_addr;
    logic [WIDTH-1:0]      r_load_data;
    logic [RCW-1:0]        r_rd;
    logic [RCW-1:0]        r_out;
    logic                  r_inflight;
    logic [1:0]            r_occ;
    logic                  r_head;
    logic [WIDTH-1:0]      r_mem [2];

    logic w_s_ready;
    logic w_s_hs;
    logic w_last_word;
    logic w_m_valid;
    logic w_m_hs;
    logic w_out_last;
    logic w_room;
    logic w_read_en;

    // r_live keeps s_ready low while rst_n is held, even though the state is LOAD
    assign w_s_ready   = r_live && (r_state == S_LOAD) && !mult_busy;
    assign w_s_hs      = s_valid && w_s_ready;
    assign w_last_word = (r_word == LAST_WORD);
    assign w_m_valid   = (r_occ != 2'd0);
    assign w_m_hs      = w_m_valid && m_ready;
    assign w_out_last  = (r_out == LAST_OUT);
    // A pop in this cycle frees a slot, so reads can stream back-to-back at full rate
    assign w_room      = (({1'b0, r_occ} + {2'b00, r_inflight}) - {2'b00, w_m_hs}) < 3'd2;
    assign w_read_en   = ((r_state == S_DRAIN) || ((r_state == S_WAIT) && mult_done))
                         && (r_rd < N_RD) && w_room;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_LOAD;
            r_live       <= 1'b0;
            r_word       <= '0;
            r_frame_err  <= 1'b0;
            r_load_coeff <= 1'b0;
            r_load_sel   <= 1'b0;
            r_load_addr  <= '0;
            r_load_data  <= '0;
            r_rd         <= '0;
            r_out        <= '0;
            r_inflight   <= 1'b0;
            r_occ        <= 2'd0;
            r_head       <= 1'b0;
            r_mem[0]     <= '0;
            r_mem[1]     <= '0;
        end else begin
            r_live       <= 1'b1;
            r_load_coeff <= w_s_hs;
            if (w_s_hs) begin
                r_load_sel  <= r_word[ADDR_WIDTH];
                r_load_addr <= r_word[ADDR_WIDTH-1:0];
                r_load_data <= s_data;
                r_word      <= w_last_word ? '0 : r_word + 1'b1;
                if (s_last != w_last_word) begin
                    r_frame_err <= 1'b1;
                end else if (r_word == '0) begin
                    r_frame_err <= 1'b0;
                end
            end

            if (w_read_en) begin
                r_rd <= r_rd + 1'b1;
            end
            r_inflight <= w_read_en;
            if (r_inflight) begin
                r_mem[r_head ^ r_occ[0]] <= mult_read_data;
            end
            if (w_m_hs) begin
                r_head <= ~r_head;
            end
            r_occ <= (r_occ + {1'b0, r_inflight}) - {1'b0, w_m_hs};

            case (r_state)
                S_LOAD:  if (w_s_hs && w_last_word) r_state <= S_FLUSH;
                S_FLUSH: r_state <= S_START;
                S_START: r_state <= S_WAIT;
                S_WAIT:  if (mult_done) r_state <= S_DRAIN;
                S_DRAIN: begin
                    if (w_m_hs && w_out_last) begin
                        r_state    <= S_LOAD;
                        r_rd       <= '0;
                        r_out      <= '0;
                        r_occ      <= 2'd0;
                        r_head     <= 1'b0;
                        r_inflight <= 1'b0;
                    end else if (w_m_hs) begin
                        r_out <= r_out + 1'b1;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign s_ready         = w_s_ready;
    assign m_valid         = w_m_valid;
    assign m_data          = r_mem[r_head];
    assign m_last          = w_m_valid && w_out_last;
    assign busy            = (r_state != S_LOAD);
    assign frame_err       = r_frame_err;
    assign mult_start      = (r_state == S_START);
    assign mult_load_coeff = r_load_coeff;
    assign mult_load_sel   = r_load_sel;
    assign mult_load_addr  = r_load_addr;
    assign mult_load_data  = r_load_data;
    assign mult_read_addr  = r_rd[ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_ntt_mult_stream_host.sv
// tb/tb_ntt_mult_stream_host.sv - scoreboard bench for ntt_mult_stream_host with a behavioural multiplier
module tb_ntt_mult_stream_host;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_data = '0;
    logic          s_last = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic          busy;
    logic          frame_err;
    logic          mult_start;
    logic          mult_done;
    logic          mult_busy;
    logic          mult_load_coeff;
    logic          mult_load_sel;
    logic [AW-1:0] mult_load_addr;
    logic [W-1:0]  mult_load_data;
    logic [AW-1:0] mult_read_addr;
    logic [W-1:0]  mult_read_data = '0;

    logic mbusy_model = 1'b0, busy_force = 1'b0, done_model = 1'b0, done_force = 1'b0;
    assign mult_busy = mbusy_model | busy_force;
    assign mult_done = done_model | done_force;

    always #5 clk = ~clk;

    ntt_mult_stream_host #(.N(N), .WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .frame_err(frame_err),
        .mult_start(mult_start), .mult_done(mult_done), .mult_busy(mult_busy),
        .mult_load_coeff(mult_load_coeff), .mult_load_sel(mult_load_sel),
        .mult_load_addr(mult_load_addr), .mult_load_data(mult_load_data),
        .mult_read_addr(mult_read_addr), .mult_read_data(mult_read_data)
    );

    typedef struct { logic sel; logic [AW-1:0] addr; logic [W-1:0] data; int cyc; } ld_t;
    typedef struct { logic [W-1:0] data; logic last; } out_t;
    ld_t  ldq[$];
    out_t outq[$];
    ld_t  le;
    out_t oe;

    int checks = 0, errors = 0, cyc = 0;
    int last_hs_cyc = -100, done_cyc = -100, seen_done = -100;
    int ready_mode = 0;
    logic [W-1:0] fw [8];
    logic [W-1:0] a_mem [N], b_mem [N], res_mem [N];
    logic [W-1:0] acc;
    logic exp_err = 1'b0;
    logic prev_stall = 1'b0, prev_last = 1'b0;
    logic [W-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctrl"}, 64'({s_ready, m_valid, m_last, busy, frame_err, mult_start,
                                 mult_load_coeff, mult_load_sel, mult_load_addr, mult_read_addr}), 64'd0);
        chk({name, "_data"}, 64'({m_data, mult_load_data}), 64'd0);
    endtask

    task automatic set_frame(input logic [W-1:0] a0, a1, a2, a3, b0, b1, b2, b3);
        fw[0] = a0; fw[1] = a1; fw[2] = a2; fw[3] = a3;
        fw[4] = b0; fw[5] = b1; fw[6] = b2; fw[7] = b3;
    endtask

    task automatic expect_out(input logic [W-1:0] r0, r1, r2, r3);
        outq.push_back('{r0, 1'b0});
        outq.push_back('{r1, 1'b0});
        outq.push_back('{r2, 1'b0});
        outq.push_back('{r3, 1'b1});
    endtask

    task automatic send_frame(input int lastpos);
        logic ok;
        for (int w = 0; w < 2*N; w++) begin
            s_valid = 1'b1;
            s_data  = fw[w];
            s_last  = (w == lastpos);
            ok = 1'b0;
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk);
                ok = s_ready;
            end
            if (!ok) chk("s_ready_timeout", 64'd1, 64'd0);
            ldq.push_back('{1'(w >= N), AW'(w % N), fw[w], cyc + 1});
            last_hs_cyc = cyc;
            if (w == 0) exp_err = 1'b0;
            if ((w == lastpos) != (w == 2*N-1)) exp_err = 1'b1;
            @(posedge clk);
            #1;
            chk("frame_err", 64'(frame_err), 64'(exp_err));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int t = 0; t < 200 && outq.size() != 0; t++) @(posedge clk);
        if (outq.size() != 0) chk({name, "_drain_timeout"}, 64'd1, 64'd0);
        #1;
        chk({name, "_idle_busy"}, 64'(busy), 64'd0);
        chk({name, "_idle_s_ready"}, 64'(s_ready), 64'd1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // behavioural multiplier: captures loads, registered read port, negacyclic product
    initial forever begin
        @(posedge clk);
        if (rst_n && mult_load_coeff) begin
            if (mult_load_sel) b_mem[mult_load_addr] <= mult_load_data;
            else               a_mem[mult_load_addr] <= mult_load_data;
        end
        mult_read_data <= res_mem[mult_read_addr];
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            a_mem[k] = '0; b_mem[k] = '0; res_mem[k] = '0;
        end
        forever begin
            @(negedge clk);
            if (rst_n && mult_start) begin
                chk("start_latency", 64'(cyc), 64'(last_hs_cyc + 2));
                @(posedge clk);
                #1 mbusy_model = 1'b1;
                @(negedge clk);
                chk("start_single_pulse", 64'(mult_start), 64'd0);
                repeat (3) @(posedge clk);
                #1;
                for (int k = 0; k < N; k++) begin
                    acc = '0;
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            if (i + j == k)          acc = acc + a_mem[i] * b_mem[j];
                            else if (i + j == k + N) acc = acc - a_mem[i] * b_mem[j];
                        end
                    end
                    res_mem[k] = acc;
                end
                done_model = 1'b1;
                done_cyc   = cyc;
                @(posedge clk);
                #1;
                done_model  = 1'b0;
                mbusy_model = 1'b0;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (ready_mode == 0) m_ready = 1'b1;
        else                 m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (mult_load_coeff) begin
                if (ldq.size() == 0) chk("load_extra", 64'd1, 64'd0);
                else begin
                    le = ldq.pop_front();
                    chk("load_word", 64'({mult_load_sel, mult_load_addr, mult_load_data}),
                        64'({le.sel, le.addr, le.data}));
                    chk("load_latency", 64'(cyc), 64'(le.cyc));
                end
            end
            if (busy) chk("s_ready_while_busy", 64'(s_ready), 64'd0);
            if (prev_stall)
                chk("stall_hold", 64'({m_valid, m_last, m_data}), 64'({1'b1, prev_last, prev_data}));
            if (m_valid && seen_done != done_cyc) begin
                chk("first_valid_latency", 64'(cyc), 64'(done_cyc + 2));
                seen_done = done_cyc;
            end
            if (m_valid && m_ready) begin
                if (outq.size() == 0) chk("out_extra", 64'd1, 64'd0);
                else begin
                    oe = outq.pop_front();
                    chk("out_word", 64'({m_last, m_data}), 64'({oe.last, oe.data}));
                    if (oe.last && ready_mode == 0)
                        chk("last_word_latency", 64'(cyc), 64'(done_cyc + N + 1));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("s_ready_after_release", 64'(s_ready), 64'd1);
        busy_force = 1'b1;
        #1;
        chk("s_ready_mult_busy", 64'(s_ready), 64'd0);
        busy_force = 1'b0;
        @(posedge clk);
        #1 done_force = 1'b1;
        @(posedge clk);
        #1 done_force = 1'b0;
        chk("done_ignored_in_load", 64'(busy), 64'd0);

        ready_mode = 0;
        set_frame(1, 0, 0, 0, 5, 6, 7, 8);
        expect_out(5, 6, 7, 8);
        send_frame(7);
        wait_drain("f1");

        ready_mode = 1;
        set_frame(0, 1, 0, 0, 1, 2, 3, 4);
        expect_out(32'hFFFF_FFFC, 1, 2, 3);
        send_frame(3);
        wait_drain("f2");
        chk("frame_err_sticky", 64'(frame_err), 64'd1);

        set_frame(3, 0, 0, 0, 10, 20, 30, 40);
        expect_out(30, 60, 90, 120);
        send_frame(7);
        wait_drain("f3");

        ready_mode = 0;
        set_frame(1, 1, 0, 0, 1, 2, 3, 4);
        expect_out(32'hFFFF_FFFD, 3, 5, 7);
        send_frame(7);
        for (int t = 0; t < 200 && outq.size() > 2; t++) @(posedge clk);
        if (outq.size() != 2) chk("mid_drain_timeout", 64'(outq.size()), 64'd2);
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("reset_mid_drain");
        outq.delete();
        ldq.delete();
        exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        set_frame(2, 0, 0, 0, 4, 3, 2, 1);
        expect_out(8, 6, 4, 2);
        send_frame(7);
        wait_drain("f5");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ntt_mult_stream_host.md
# ntt_mult_stream_host

Host-side sequencer that drives the load/start/done/read port of the NTT polynomial multiplier from AXI-Stream-style interfaces. It accepts one frame of 2·N coefficients (A, then B) on a valid/ready input stream and writes them into the multiplier. It then starts the multiplier, waits for completion, and streams the N result coefficients out on a valid/ready output stream with backpressure. It sits between the system interconnect and the multiplier and owns every multiplier control input.

## Interface
- N, 256, coefficients per polynomial (power of two)
- WIDTH, 32, coefficient width
- ADDR_WIDTH, 8, log2(N)
- Reset is rst_n, asynchronous, active-low. Clock is clk.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input coefficient valid
- s_ready  out  1  input coefficient ready
- s_data  in  WIDTH  input coefficient; words 0..N-1 = A, N..2N-1 = B
- s_last  in  1  end-of-frame marker; expected on word 2N-1
- m_valid  out  1  result coefficient valid
- m_ready  in  1  result coefficient ready
- m_data  out  WIDTH  result coefficient
- m_last  out  1  marks result word N-1
- busy  out  1  high in every state except LOAD
- frame_err  out  1  sticky s_last mismatch flag
- mult_start  out  1  multiplier start pulse
- mult_done  in  1  multiplier done (single-cycle pulse)
- mult_busy  in  1  multiplier busy
- mult_load_coeff, mult_load_sel  out  1, 1  load strobe; sel 0 = A, 1 = B
- mult_load_addr  out  ADDR_WIDTH  load address
- mult_load_data  out  WIDTH  load data
- mult_read_addr  out  ADDR_WIDTH  result read address
- mult_read_data  in  WIDTH  result data, valid one cycle after its address

## Operation
- States: LOAD, FLUSH, START, WAIT, DRAIN.
- LOAD:
  - s_ready = !mult_busy.
  - Each handshake at word index w (0..2N-1) registers mult_load_coeff=1, mult_load_sel=(w≥N), mult_load_addr=w mod N, mult_load_data=s_data for the next cycle.
  - Without a handshake, mult_load_coeff=0 in the next cycle.
  - Handshake of word 2N-1 -> FLUSH.
- frame_err:
  - Set when s_last=1 on any word other than 2N-1, or s_last=0 on word 2N-1.
  - Cleared on the handshake of word 0 of the next frame. The set condition takes priority in the same cycle.
  - A frame always spans exactly 2N words regardless of s_last.
- FLUSH: one cycle in which the registered load of word 2N-1 is presented. Goes to START.
- START: mult_start=1 for exactly one cycle. Goes to WAIT.
- WAIT: mult_start=0. On mult_done=1, go to DRAIN and reset the read index r and out index o to 0.
- DRAIN:
  - Issues mult_read_addr=r and increments r when r<N and (buffer occupancy + in-flight reads) < 2.
  - Data returning one cycle later is pushed into a 2-entry output FIFO.
  - m_valid = FIFO not empty.
  - m_last = 1 when the head entry is result index N-1.
  - On the handshake with o=N-1, go to LOAD with counters and FIFO empty.
- Word counter width is $clog2(2N+1). No counter wraps within a frame.

## Timing
- Reset values: all outputs 0, state LOAD, counters 0, FIFO empty.
- s_ready becomes 1 in the first cycle after reset release if mult_busy=0.
- Reset mid-frame or mid-drain abandons the frame. The multiplier resets on the same rst_n.
- Load latency: s handshake at cycle k -> mult_load_coeff at cycle k+1.
- mult_start asserts 2 cycles after the handshake of the last word.
- Read latency: first m_valid asserts 2 cycles after the mult_done cycle.
- With m_ready held at 1, output sustains 1 word/cycle. The last word appears N+1 cycles after the mult_done cycle.
- With m_ready=0: m_data/m_last are held stable and no read is issued once occupancy+in-flight = 2. No data is lost.
- s_ready is 0 from FLUSH through DRAIN, and also in LOAD while mult_busy=1.
- If mult_done asserts outside WAIT, it is ignored.
- Simultaneous FIFO push and pop in one cycle keeps occupancy unchanged.

## Test plan
- Reset release, s_valid=0 -> all outputs 0; s_ready=1 at the first cycle after release.
- N=4, A=[1,0,0,0], B=[5,6,7,8], s_last on word 7 -> 8 mult_load_coeff pulses with addr 0..3 sel 0 then 0..3 sel 1. mult_start pulses 2 cycles after word 7. Model done -> m_data 5,6,7,8 with m_last on 8, frame_err=0.
- Same frame with s_last on word 3 -> frame_err=1 after word 3. Frame still completes 8 loads. Next frame's word 0 clears frame_err.
- During drain, m_ready toggles 1,0,0,1,... -> no dropped or duplicated words. m_data stays stable while stalled. Occupancy+in-flight never exceeds 2.
- m_ready=1 throughout drain -> N consecutive m_valid cycles starting 2 cycles after mult_done.
- rst_n asserted mid-DRAIN at o=2 -> outputs 0 immediately. After release, a new full frame is accepted and its results are correct.
